// File: rtl/game_pkg.sv
// rtl/game_pkg.sv - shared constants for the VGA game core input path
package game_pkg;

    localparam int NUM_BTN = 4;

    localparam int BTN_LEFT_UP    = 0;
    localparam int BTN_LEFT_DOWN  = 1;
    localparam int BTN_RIGHT_UP   = 2;
    localparam int BTN_RIGHT_DOWN = 3;

    // Roughly 5 ms of stability at the 25.125 MHz pixel clock.
    localparam int DEFAULT_DEBOUNCE_CYCLES = 125000;
    localparam int DEFAULT_CNT_W           = 17;

endpackage

// File: rtl/button_conditioner_if.sv
// rtl/button_conditioner_if.sv - raw button pins in, conditioned paddle controls out
interface button_conditioner_if;
    import game_pkg::*;

    logic [NUM_BTN-1:0] btn_n_raw;
    logic [NUM_BTN-1:0] btn_level;
    logic [NUM_BTN-1:0] btn_press;
    logic               left_up;
    logic               left_down;
    logic               right_up;
    logic               right_down;

    modport master (
        input  btn_n_raw,
        output btn_level,
        output btn_press,
        output left_up,
        output left_down,
        output right_up,
        output right_down
    );

    modport slave (
        output btn_n_raw,
        input  btn_level,
        input  btn_press,
        input  left_up,
        input  left_down,
        input  right_up,
        input  right_down
    );

endinterface

// File: rtl/debounce_channel.sv
// rtl/debounce_channel.sv - two-flop synchronizer, debounce counter and press pulse for one pin
module debounce_channel #(
    parameter int DEBOUNCE_CYCLES = 125000,
    parameter int CNT_W           = 17
) (
    input  logic clk,
    input  logic rst_n,
    input  logic pin_n,
    output logic level,
    output logic press
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1;
    logic             sync2;
    logic             sampled;
    logic [CNT_W-1:0] cnt;

    assign sampled = ~sync2;

    // Any cycle agreeing with the current level restarts the count, so only an
    // unbroken run of DEBOUNCE_CYCLES disagreeing samples moves the level.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
            level <= 1'b0;
            cnt   <= '0;
            press <= 1'b0;
        end else begin
            sync1 <= pin_n;
            sync2 <= sync1;
            press <= 1'b0;
            if (sampled == level) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                level <= sampled;
                cnt   <= '0;
                press <= sampled;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/button_conditioner.sv
// rtl/button_conditioner.sv - debounces the four PMOD buttons and masks contradictory paddle requests
module button_conditioner
    import game_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter int CNT_W           = DEFAULT_CNT_W
) (
    input  logic                 clk,
    input  logic                 rst_n,
    button_conditioner_if.master bus
);

    logic [NUM_BTN-1:0] level;
    logic [NUM_BTN-1:0] press;

    for (genvar i = 0; i < NUM_BTN; i++) begin : g_ch
        debounce_channel #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .CNT_W           (CNT_W)
        ) u_ch (
            .clk   (clk),
            .rst_n (rst_n),
            .pin_n (bus.btn_n_raw[i]),
            .level (level[i]),
            .press (press[i])
        );
    end

    assign bus.btn_level = level;
    assign bus.btn_press = press;

    // Holding both directions on one side reads as no movement for that paddle.
    assign bus.left_up    = level[BTN_LEFT_UP]    & ~level[BTN_LEFT_DOWN];
    assign bus.left_down  = level[BTN_LEFT_DOWN]  & ~level[BTN_LEFT_UP];
    assign bus.right_up   = level[BTN_RIGHT_UP]   & ~level[BTN_RIGHT_DOWN];
    assign bus.right_down = level[BTN_RIGHT_DOWN] & ~level[BTN_RIGHT_UP];

endmodule

// File: tb/tb_button_conditioner.sv
// tb/tb_button_conditioner.sv - directed self-checking bench for button_conditioner
module tb_button_conditioner;

    logic clk;
    logic rst_n;
    int   n_tests;
    int   n_fail;
    logic bounce_seen;

    button_conditioner_if bus ();

    button_conditioner #(
        .DEBOUNCE_CYCLES (8),
        .CNT_W           (4)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [3:0] pads();
        return {bus.right_down, bus.right_up, bus.left_down, bus.left_up};
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        bounce_seen = 1'b0;
        rst_n = 1'b0;
        bus.btn_n_raw = 4'b0000;

        // Reset with every pin held pressed.
        for (int i = 0; i < 3; i++) begin
            tick(1);
            check("rst_level", bus.btn_level, 4'b0000);
            check("rst_press", bus.btn_press, 4'b0000);
            check("rst_pads", pads(), 4'b0000);
        end
        rst_n = 1'b1;
        tick(9);
        check("rel_level_early", bus.btn_level, 4'b0000);
        check("rel_press_early", bus.btn_press, 4'b0000);
        tick(1);
        check("rel_level", bus.btn_level, 4'b1111);
        check("rel_press", bus.btn_press, 4'b1111);
        check("rel_pads_masked", pads(), 4'b0000);
        tick(1);
        check("rel_press_once", bus.btn_press, 4'b0000);
        check("rel_level_hold", bus.btn_level, 4'b1111);

        bus.btn_n_raw = 4'b1111;
        tick(9);
        check("all_up_early", bus.btn_level, 4'b1111);
        tick(1);
        check("all_up_level", bus.btn_level, 4'b0000);
        check("all_up_nopulse", bus.btn_press, 4'b0000);

        // Clean press and release of left_up.
        bus.btn_n_raw = 4'b1110;
        tick(9);
        check("clean_early", bus.btn_level, 4'b0000);
        tick(1);
        check("clean_level", bus.btn_level, 4'b0001);
        check("clean_press", bus.btn_press, 4'b0001);
        check("clean_pads", pads(), 4'b0001);
        tick(1);
        check("clean_press_once", bus.btn_press, 4'b0000);
        bus.btn_n_raw = 4'b1111;
        tick(9);
        check("clean_rel_early", bus.btn_level, 4'b0001);
        tick(1);
        check("clean_rel_level", bus.btn_level, 4'b0000);
        check("clean_rel_nopulse", bus.btn_press, 4'b0000);
        check("clean_rel_pads", pads(), 4'b0000);

        // Bounce on right_up: two 7-cycle lows are rejected.
        for (int r = 0; r < 2; r++) begin
            bus.btn_n_raw = 4'b1011;
            for (int i = 0; i < 7; i++) begin
                tick(1);
                if (bus.btn_level[2] || bus.btn_press[2]) bounce_seen = 1'b1;
            end
            bus.btn_n_raw = 4'b1111;
            tick(1);
            if (bus.btn_level[2] || bus.btn_press[2]) bounce_seen = 1'b1;
        end
        bus.btn_n_raw = 4'b1011;
        for (int i = 0; i < 9; i++) begin
            tick(1);
            if (bus.btn_level[2] || bus.btn_press[2]) bounce_seen = 1'b1;
        end
        check("bounce_rejected", bounce_seen, 1'b0);
        tick(1);
        check("bounce_level", bus.btn_level, 4'b0100);
        check("bounce_press", bus.btn_press, 4'b0100);
        check("bounce_pads", pads(), 4'b0100);
        bus.btn_n_raw = 4'b1111;
        tick(12);
        check("bounce_released", bus.btn_level, 4'b0000);

        // Conflict on the left side.
        bus.btn_n_raw = 4'b1100;
        tick(10);
        check("conf_level", bus.btn_level, 4'b0011);
        check("conf_press", bus.btn_press, 4'b0011);
        check("conf_pads", pads(), 4'b0000);
        bus.btn_n_raw = 4'b1110;
        tick(9);
        check("conf_rel_early_pads", pads(), 4'b0000);
        tick(1);
        check("conf_rel_level", bus.btn_level, 4'b0001);
        check("conf_rel_pads", pads(), 4'b0001);
        bus.btn_n_raw = 4'b1111;
        tick(11);
        check("conf_clear", bus.btn_level, 4'b0000);

        // Reset while right_down is mid-count (cnt reaches 5 after 7 ticks).
        bus.btn_n_raw = 4'b0111;
        tick(7);
        rst_n = 1'b0;
        tick(1);
        check("mid_rst_level", bus.btn_level, 4'b0000);
        check("mid_rst_press", bus.btn_press, 4'b0000);
        rst_n = 1'b1;
        tick(9);
        check("mid_rst_early", bus.btn_level, 4'b0000);
        tick(1);
        check("mid_rst_level_up", bus.btn_level, 4'b1000);
        check("mid_rst_press_up", bus.btn_press, 4'b1000);
        check("mid_rst_pads", pads(), 4'b1000);
        bus.btn_n_raw = 4'b1111;
        tick(11);
        check("mid_rst_clear", bus.btn_level, 4'b0000);

        // Simultaneous presses while left_up is already held.
        bus.btn_n_raw = 4'b1110;
        tick(10);
        check("ind_hold_level", bus.btn_level, 4'b0001);
        tick(1);
        bus.btn_n_raw = 4'b0100;
        tick(9);
        check("ind_early", bus.btn_level, 4'b0001);
        check("ind_early_press", bus.btn_press, 4'b0000);
        tick(1);
        check("ind_press", bus.btn_press, 4'b1010);
        check("ind_level", bus.btn_level, 4'b1011);
        check("ind_pads", pads(), 4'b1000);
        tick(1);
        check("ind_press_once", bus.btn_press, 4'b0000);
        check("ind_level_hold", bus.btn_level, 4'b1011);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
